channel_broadcast_expander: RTL and testbench

- Inverse of the squeeze stage: takes a vector of NUM_CHANNELS per-channel scalars on AXI4-Stream and re-expands it into a full channel-major feature-map stream of NUM_CHANNELS x FEATURE_MAP_SIZE^2 beats.
- Each scalar is repeated for every spatial position of its channel.
- Sits downstream of the excitation path, where it feeds element-wise scale/add units that consume a full feature map. It also serves as a test-pattern source for pooling blocks.

---
 rtl/channel_broadcast_expander.sv | 113 +++++++++++
 tb/tb_channel_broadcast_expander.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/channel_broadcast_expander.sv
// channel_broadcast_expander: repeats each of NUM_CHANNELS scalars over FEATURE_MAP_SIZE^2 beats, channel-major.
// Define CBE_DOUBLE_BUFFER_EN for two storage banks so the next vector loads while the current one emits.
module channel_broadcast_expander #(
  parameter int DATA_WIDTH       = 16,
  parameter int NUM_CHANNELS     = 64,
  parameter int FEATURE_MAP_SIZE = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  len_err,
  output logic                  busy
);
  localparam int SP_N = FEATURE_MAP_SIZE * FEATURE_MAP_SIZE;
  localparam int CW   = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam int SW   = SP_N > 1 ? $clog2(SP_N) : 1;
`ifdef CBE_DOUBLE_BUFFER_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam bit DB = NB == 2;
  localparam logic [CW-1:0] CH_LAST = CW'(NUM_CHANNELS - 1);
  localparam logic [SW-1:0] SP_LAST = SW'(SP_N - 1);

  typedef enum logic {LOAD, EMIT} state_t;
  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_q [NB][NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]         wr_idx_q, wr_idx_d, ch_q, ch_d;
  logic [SW-1:0]         sp_q, sp_d;
  logic [NB-1:0]         full_q, full_d;
  logic                  wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic                  last_q, last_d, len_err_q, len_err_d;
  logic                  s_hs, m_hs, wr_last, fill, nx_bank, avail_rd, avail_nx, map_done, go;

  assign s_hs     = s_axis_tvalid && s_axis_tready;
  assign m_hs     = m_axis_tvalid && m_axis_tready;
  assign wr_last  = wr_idx_q == CH_LAST;
  assign fill     = s_hs && wr_last;
  assign nx_bank  = rd_bank_q ^ DB;
  assign map_done = m_hs && last_q;
  // A bank counts as available in the very cycle its final scalar lands, giving 1-cycle latency.
  assign avail_rd = full_q[rd_bank_q] || (fill && wr_bank_q == rd_bank_q);
  assign avail_nx = DB && (full_q[nx_bank] || (fill && wr_bank_q == nx_bank));
  assign go       = (state_q == LOAD && avail_rd) || (map_done && avail_nx);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;

  always_comb
    state_d = go ? EMIT : map_done ? LOAD : state_q;

  always_comb begin
    m_axis_tvalid = state_q == EMIT;
    busy          = state_q == EMIT;
    s_axis_tready = !full_q[wr_bank_q];
    m_axis_tdata  = data_q;
    m_axis_tlast  = last_q;
    len_err       = len_err_q;
  end

  always_comb begin
    wr_idx_d  = s_hs ? (wr_last ? '0 : wr_idx_q + CW'(1)) : wr_idx_q;
    wr_bank_d = fill ? wr_bank_q ^ DB : wr_bank_q;
    rd_bank_d = map_done ? nx_bank : rd_bank_q;
    sp_d      = go ? '0 : m_hs ? (sp_q == SP_LAST ? '0 : sp_q + SW'(1)) : sp_q;
    ch_d      = go ? '0 : (m_hs && sp_q == SP_LAST) ? (ch_q == CH_LAST ? '0 : ch_q + CW'(1)) : ch_q;
    full_d    = full_q;
    if (fill) full_d[wr_bank_q] = 1'b1;
    if (map_done) full_d[rd_bank_q] = 1'b0;
    // Bypass covers a one-channel vector whose only scalar is being written as emission starts.
    data_d    = state_d != EMIT ? '0 :
                (s_hs && wr_bank_q == rd_bank_d && wr_idx_q == ch_d) ? s_axis_tdata : mem_q[rd_bank_d][ch_d];
    last_d    = state_d == EMIT && ch_d == CH_LAST && sp_d == SP_LAST;
    len_err_d = s_hs && (s_axis_tlast != wr_last);
  end

  always_ff @(posedge clk)
    if (s_hs) mem_q[wr_bank_q][wr_idx_q] <= s_axis_tdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_idx_q  <= '0;
      ch_q      <= '0;
      sp_q      <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      ch_q      <= ch_d;
      sp_q      <= sp_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      data_q    <= data_d;
      last_q    <= last_d;
      len_err_q <= len_err_d;
    end
endmodule

// File: tb/tb_channel_broadcast_expander.sv
// tb_channel_broadcast_expander: directed scenarios on a 4-channel 2x2 instance and a 1-channel 1x1 instance.
module tb_channel_broadcast_expander;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic [15:0] s_tdata = '0, m_tdata;
  logic s_tvalid = 0, s_tlast = 0, s_tready, m_tvalid, m_tready = 1, m_tlast, len_err, busy;
  logic [15:0] b_s_tdata = '0, b_m_tdata;
  logic b_s_tvalid = 0, b_s_tlast = 0, b_s_tready, b_m_tvalid, b_m_tlast, b_len_err, b_busy;

  channel_broadcast_expander #(.DATA_WIDTH(16), .NUM_CHANNELS(4), .FEATURE_MAP_SIZE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .len_err(len_err), .busy(busy));

  channel_broadcast_expander #(.DATA_WIDTH(16), .NUM_CHANNELS(1), .FEATURE_MAP_SIZE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready), .s_axis_tlast(b_s_tlast),
    .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(1'b1), .m_axis_tlast(b_m_tlast),
    .len_err(b_len_err), .busy(b_busy));

  int total = 0, passed = 0;
  logic [15:0] vec [4];
  logic [15:0] cap_d [64];
  logic        cap_l [64];
  int cap_n, gaps, rdy_hi, hold_bad;
  logic [3:0] errs, pre_tv;

  task automatic load(input logic [3:0] lasts);
    for (int i = 0; i < 4; i++) begin
      s_tdata = vec[i]; s_tlast = lasts[i]; s_tvalid = 1; pre_tv[i] = m_tvalid;
      @(negedge clk);
      errs[i] = len_err;
    end
    s_tvalid = 0; s_tlast = 0;
  endtask

  task automatic collect(input bit stall, input int n);
    logic [17:0] prev;
    bit prev_stall;
    int cyc;
    cap_n = 0; gaps = 0; rdy_hi = 0; hold_bad = 0; prev = '0; prev_stall = 0; cyc = 0;
    while (cap_n < n && cyc < 300) begin
      m_tready = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      if (!m_tvalid) gaps++;
      if (m_tvalid && s_tready) rdy_hi++;
      if (prev_stall && {m_tvalid, m_tdata, m_tlast} !== prev) hold_bad++;
      prev = {m_tvalid, m_tdata, m_tlast};
      prev_stall = m_tvalid && !m_tready;
      if (m_tvalid && m_tready) begin cap_d[cap_n] = m_tdata; cap_l[cap_n] = m_tlast; cap_n++; end
      cyc++;
      @(negedge clk);
    end
    m_tready = 1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++; if ({s_tready, m_tvalid, m_tlast, busy, len_err} !== 5'b10000) $display("FAIL reset_ctrl: got %b want 10000", {s_tready, m_tvalid, m_tlast, busy, len_err}); else passed++;
    total++; if (m_tdata !== 16'h0) $display("FAIL reset_tdata: got %h want 0000", m_tdata); else passed++;
    total++; if ({b_s_tready, b_m_tvalid, b_m_tlast, b_busy, b_len_err} !== 5'b10000) $display("FAIL reset_tiny: got %b want 10000", {b_s_tready, b_m_tvalid, b_m_tlast, b_busy, b_len_err}); else passed++;
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    vec = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    load(4'b1000);
    total++; if (pre_tv !== 4'b0000) $display("FAIL basic_early_valid: got %b want 0000", pre_tv); else passed++;
    total++; if (errs !== 4'b0000) $display("FAIL basic_len_err: got %b want 0000", errs); else passed++;
    total++; if ({m_tvalid, busy} !== 2'b11) $display("FAIL basic_latency: got %b want 11", {m_tvalid, busy}); else passed++;
`ifndef CBE_DOUBLE_BUFFER_EN
    total++; if (s_tready !== 1'b0) $display("FAIL basic_tready_emit: got %b want 0", s_tready); else passed++;
`endif
    collect(0, 16);
    total++; if (cap_n !== 16) $display("FAIL basic_count: got %0d want 16", cap_n); else passed++;
    for (int j = 0; j < 16; j++) begin
      total++; if (cap_d[j] !== vec[j / 4] || cap_l[j] !== (j == 15)) $display("FAIL basic_beat%0d: got %h/%b want %h/%b", j, cap_d[j], cap_l[j], vec[j / 4], j == 15); else passed++;
    end
    total++; if (gaps !== 0) $display("FAIL basic_gaps: got %0d want 0", gaps); else passed++;
`ifndef CBE_DOUBLE_BUFFER_EN
    total++; if (rdy_hi !== 0) $display("FAIL basic_tready_during: got %0d want 0", rdy_hi); else passed++;
`endif
    total++; if ({m_tvalid, s_tready, busy} !== 3'b010) $display("FAIL basic_done: got %b want 010", {m_tvalid, s_tready, busy}); else passed++;
  endtask

  task automatic test_stall;
    vec = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    load(4'b1000);
    collect(1, 16);
    total++; if (cap_n !== 16) $display("FAIL stall_count: got %0d want 16", cap_n); else passed++;
    for (int j = 0; j < 16; j++) begin
      total++; if (cap_d[j] !== vec[j / 4] || cap_l[j] !== (j == 15)) $display("FAIL stall_beat%0d: got %h/%b want %h/%b", j, cap_d[j], cap_l[j], vec[j / 4], j == 15); else passed++;
    end
    total++; if (hold_bad !== 0) $display("FAIL stall_hold: got %0d changes want 0", hold_bad); else passed++;
    total++; if (m_tvalid !== 1'b0) $display("FAIL stall_done: got %b want 0", m_tvalid); else passed++;
  endtask

  task automatic test_len_err;
    vec = '{16'h00a1, 16'h00a2, 16'h00a3, 16'h00a4};
    load(4'b0010);
    total++; if (errs !== 4'b1010) $display("FAIL len_err_pulses: got %b want 1010", errs); else passed++;
    total++; if (m_tvalid !== 1'b1) $display("FAIL len_err_emit: got %b want 1", m_tvalid); else passed++;
    collect(0, 16);
    total++; if (cap_n !== 16 || cap_d[0] !== 16'h00a1 || cap_d[15] !== 16'h00a4 || cap_l[15] !== 1'b1) $display("FAIL len_err_map: got n=%0d %h %h %b want n=16 00a1 00a4 1", cap_n, cap_d[0], cap_d[15], cap_l[15]); else passed++;
    total++; if (len_err !== 1'b0) $display("FAIL len_err_clear: got %b want 0", len_err); else passed++;
  endtask

  task automatic test_reset_mid;
    vec = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    load(4'b1000);
    collect(0, 6);
    total++; if (cap_n !== 6) $display("FAIL rmid_pre: got %0d want 6", cap_n); else passed++;
    rst_n = 0;
    #1;
    total++; if ({m_tvalid, s_tready, busy, m_tlast} !== 4'b0100) $display("FAIL rmid_async: got %b want 0100", {m_tvalid, s_tready, busy, m_tlast}); else passed++;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    vec = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    load(4'b1000);
    collect(0, 16);
    total++; if (cap_n !== 16) $display("FAIL rmid_count: got %0d want 16", cap_n); else passed++;
    for (int j = 0; j < 16; j++) begin
      total++; if (cap_d[j] !== vec[j / 4] || cap_l[j] !== (j == 15)) $display("FAIL rmid_beat%0d: got %h/%b want %h/%b", j, cap_d[j], cap_l[j], vec[j / 4], j == 15); else passed++;
    end
  endtask

  task automatic test_tiny;
    b_s_tdata = 16'hBEEF; b_s_tlast = 1; b_s_tvalid = 1;
    @(negedge clk);
    b_s_tvalid = 0; b_s_tlast = 0;
    total++; if ({b_m_tvalid, b_m_tlast, b_len_err, b_busy} !== 4'b1101) $display("FAIL tiny_ctrl: got %b want 1101", {b_m_tvalid, b_m_tlast, b_len_err, b_busy}); else passed++;
    total++; if (b_m_tdata !== 16'hBEEF) $display("FAIL tiny_data: got %h want beef", b_m_tdata); else passed++;
`ifndef CBE_DOUBLE_BUFFER_EN
    total++; if (b_s_tready !== 1'b0) $display("FAIL tiny_tready_emit: got %b want 0", b_s_tready); else passed++;
`endif
    @(negedge clk);
    total++; if ({b_m_tvalid, b_s_tready, b_busy} !== 3'b010) $display("FAIL tiny_done: got %b want 010", {b_m_tvalid, b_s_tready, b_busy}); else passed++;
  endtask

`ifdef CBE_DOUBLE_BUFFER_EN
  task automatic test_back_to_back;
    logic [15:0] exp [32];
    vec = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    for (int j = 0; j < 16; j++) exp[j] = vec[j / 4];
    load(4'b1000);
    vec = '{16'h0055, 16'h0066, 16'h0077, 16'h0088};
    for (int j = 0; j < 16; j++) exp[16 + j] = vec[j / 4];
    fork
      load(4'b1000);
      collect(0, 32);
    join
    total++; if (cap_n !== 32) $display("FAIL b2b_count: got %0d want 32", cap_n); else passed++;
    for (int j = 0; j < 32; j++) begin
      total++; if (cap_d[j] !== exp[j] || cap_l[j] !== (j == 15 || j == 31)) $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", j, cap_d[j], cap_l[j], exp[j], j == 15 || j == 31); else passed++;
    end
    total++; if (gaps !== 0) $display("FAIL b2b_gaps: got %0d want 0", gaps); else passed++;
    total++; if (m_tvalid !== 1'b0) $display("FAIL b2b_done: got %b want 0", m_tvalid); else passed++;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_len_err;
    test_reset_mid;
    test_tiny;
`ifdef CBE_DOUBLE_BUFFER_EN
    test_back_to_back;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
